cache_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction L1 path (I side) and the data L1/victim-cache path (D side).
- Sits between the two L1 miss/writeback interfaces and pmem.
- Latches the winning request, then holds it on pmem until pmem_resp, then returns the response to the winner.
- Round-robin on simultaneous requests; saturating per-side grant counters for performance visibility.

---
 rtl/cache_arbiter_pkg.sv | 8 +
 rtl/cache_arbiter_if.sv | 14 +
 rtl/cache_arbiter_sat_counter.sv | 16 +
 rtl/cache_arbiter.sv | 96 +++++++++
 tb/tb_cache_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D to physical-memory arbiter.
package cache_arbiter_pkg;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic       {SRC_I, SRC_D}           arb_src_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// One line-granular memory port; master issues commands, slave answers them.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;

    logic         read;
    logic         write;
    lc3b_word     address;
    lc3b_mem_data wdata;
    logic         resp;
    lc3b_mem_data rdata;

    modport master (output read, write, address, wdata, input resp, rdata);
    modport slave  (input read, write, address, wdata, output resp, rdata);
endinterface

// File: rtl/cache_arbiter_sat_counter.sv
// Grant counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/cache_arbiter.sv
// Round-robin share of the single pmem port between the I and D L1 paths.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_arbiter_if.slave       i_mem,
    cache_arbiter_if.slave       d_mem,
    cache_arbiter_if.master      pmem,
    output logic [CNT_WIDTH-1:0] i_grant_count,
    output logic [CNT_WIDTH-1:0] d_grant_count
);
    arb_state_t   state, next_state;
    arb_src_t     last_grant;
    logic         i_req, d_req, grant_i, grant_d;
    logic         win_read, win_write;
    lc3b_word     win_address;
    lc3b_mem_data win_wdata;

    always_comb begin
        i_req   = i_mem.read | i_mem.write;
        d_req   = d_mem.read | d_mem.write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                grant_d = (last_grant == SRC_I);
                grant_i = ~grant_d;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end

        // Write wins if a requester illegally raises both strobes.
        win_write   = grant_d ? d_mem.write   : i_mem.write;
        win_read    = (grant_d ? d_mem.read   : i_mem.read) & ~win_write;
        win_address = grant_d ? d_mem.address : i_mem.address;
        win_wdata   = grant_d ? d_mem.wdata   : i_mem.wdata;

        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d)      next_state = SERVE_D;
                else if (grant_i) next_state = SERVE_I;
            end
            SERVE_I, SERVE_D: if (pmem.resp) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        i_mem.resp = (state == SERVE_I) && pmem.resp;
        d_mem.resp = (state == SERVE_D) && pmem.resp;
    end

    assign i_mem.rdata = pmem.rdata;
    assign d_mem.rdata = pmem.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= SRC_I;
            pmem.read    <= 1'b0;
            pmem.write   <= 1'b0;
            pmem.address <= '0;
            pmem.wdata   <= '0;
        end else begin
            state <= next_state;
            if (grant_i || grant_d) begin
                pmem.read    <= win_read;
                pmem.write   <= win_write;
                pmem.address <= win_address;
                pmem.wdata   <= win_wdata;
                last_grant   <= grant_d ? SRC_D : SRC_I;
            end else if ((state != IDLE) && pmem.resp) begin
                pmem.read  <= 1'b0;
                pmem.write <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_i),
        .count (i_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_d),
        .count (d_grant_count)
    );
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench: expected pmem transactions queued at stimulus, checked when pmem issues them.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic         wr;
        lc3b_word     addr;
        lc3b_mem_data wdata;
        arb_src_t     side;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] i_cnt, d_cnt;
    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            waited;

    cache_arbiter_if i_if ();
    cache_arbiter_if d_if ();
    cache_arbiter_if p_if ();

    cache_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_mem         (i_if),
        .d_mem         (d_if),
        .pmem          (p_if),
        .i_grant_count (i_cnt),
        .d_grant_count (d_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input arb_src_t s, input logic rd, input logic wr,
                         input lc3b_word a, input lc3b_mem_data wd);
        if (s == SRC_I) begin
            i_if.read = rd; i_if.write = wr; i_if.address = a; i_if.wdata = wd;
        end else begin
            d_if.read = rd; d_if.write = wr; d_if.address = a; d_if.wdata = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p_if.resp = 1'b0;
        drive(SRC_I, 0, 0, '0, '0);
        drive(SRC_D, 0, 0, '0, '0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory model: waits for a command, checks it against the scoreboard,
    // holds it lat cycles, then answers for one cycle.
    task automatic mem_serve(input int lat, input lc3b_mem_data rd, input bit drop,
                             output int w);
        exp_t e;
        w = 0;
        while (!(p_if.read | p_if.write) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("cmd_write", p_if.write, e.wr);
        chk("cmd_read", p_if.read, !e.wr);
        chk("cmd_addr", p_if.address, e.addr);
        chk("cmd_wdata", p_if.wdata, e.wdata);
        repeat (lat) @(negedge clk);
        chk("hold_addr", p_if.address, e.addr);
        chk("hold_wdata", p_if.wdata, e.wdata);
        p_if.resp = 1'b1;
        p_if.rdata = rd;
        #1;
        if (e.side == SRC_I) begin
            chk("i_resp", i_if.resp, 1);
            chk("d_resp_quiet", d_if.resp, 0);
            chk("i_rdata", i_if.rdata, rd);
        end else begin
            chk("d_resp", d_if.resp, 1);
            chk("i_resp_quiet", i_if.resp, 0);
            chk("d_rdata", d_if.rdata, rd);
        end
        @(negedge clk);
        p_if.resp = 1'b0;
        if (drop) drive(e.side, 0, 0, '0, '0);
        chk("dead_cycle", p_if.read | p_if.write, 0);
    endtask

    initial begin
        exp_t e;
        p_if.rdata = '0;
        do_reset();

        // reset state
        chk("rst_pread", p_if.read, 0);
        chk("rst_pwrite", p_if.write, 0);
        chk("rst_paddr", p_if.address, 0);
        chk("rst_pwdata", p_if.wdata, 0);
        chk("rst_icnt", i_cnt, 0);
        chk("rst_dcnt", d_cnt, 0);
        chk("rst_iresp", i_if.resp, 0);
        chk("rst_dresp", d_if.resp, 0);

        // lone I read
        drive(SRC_I, 1, 0, 16'h1230, '0);
        sb.push_back('{1'b0, 16'h1230, '0, SRC_I});
        @(negedge clk);
        chk("t1_pread_n1", p_if.read, 1);
        chk("t1_icnt_n1", i_cnt, 1);
        mem_serve(2, {16{8'hA5}}, 1, waited);
        chk("t1_latency", waited, 0);
        chk("t1_icnt", i_cnt, 1);
        chk("t1_dcnt", d_cnt, 0);

        // simultaneous: D wins the first tie, I follows
        do_reset();
        drive(SRC_I, 1, 0, 16'h0040, '0);
        drive(SRC_D, 0, 1, 16'h8000, {8{16'hDEAD}});
        sb.push_back('{1'b1, 16'h8000, {8{16'hDEAD}}, SRC_D});
        sb.push_back('{1'b0, 16'h0040, '0, SRC_I});
        @(negedge clk);
        mem_serve(1, 128'h1, 1, waited);
        mem_serve(0, 128'h2, 1, waited);
        chk("t2_i_next", waited, 1);
        chk("t2_icnt", i_cnt, 1);
        chk("t2_dcnt", d_cnt, 1);

        // continuous requests alternate D,I,D,I...
        do_reset();
        drive(SRC_I, 1, 0, 16'h0100, '0);
        drive(SRC_D, 1, 0, 16'h0200, '0);
        for (int k = 0; k < 10; k++) begin
            e.wr = 1'b0; e.wdata = '0;
            e.side = (k % 2 == 0) ? SRC_D : SRC_I;
            e.addr = (k % 2 == 0) ? 16'h0200 : 16'h0100;
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            mem_serve(k % 3, 128'(k), 0, waited);
            if (k > 0) chk("t3_b2b", waited, 1);
        end
        drive(SRC_I, 0, 0, '0, '0);
        drive(SRC_D, 0, 0, '0, '0);
        @(negedge clk);
        chk("t3_icnt", i_cnt, 5);
        chk("t3_dcnt", d_cnt, 5);

        // requester changes fields while being served; latched values hold
        drive(SRC_D, 0, 1, 16'h4444, {4{32'hCAFEF00D}});
        sb.push_back('{1'b1, 16'h4444, {4{32'hCAFEF00D}}, SRC_D});
        @(negedge clk);
        drive(SRC_D, 1, 0, 16'h9999, {4{32'h12345678}});
        mem_serve(3, 128'h3, 1, waited);

        // illegal read+write: write wins
        drive(SRC_I, 1, 1, 16'h0ABC, 128'h77);
        sb.push_back('{1'b1, 16'h0ABC, 128'h77, SRC_I});
        @(negedge clk);
        mem_serve(0, 128'h4, 1, waited);

        // stray resp in IDLE is dropped
        p_if.resp = 1'b1;
        #1;
        chk("stray_iresp", i_if.resp, 0);
        chk("stray_dresp", d_if.resp, 0);
        @(negedge clk);
        p_if.resp = 1'b0;
        chk("stray_idle", p_if.read | p_if.write, 0);
        chk("stray_icnt", i_cnt, 6);

        // resp in the grant cycle is ignored, then normal service
        drive(SRC_I, 1, 0, 16'h0555, '0);
        sb.push_back('{1'b0, 16'h0555, '0, SRC_I});
        p_if.resp = 1'b1;
        #1;
        chk("grant_resp_ign", i_if.resp, 0);
        @(negedge clk);
        p_if.resp = 1'b0;
        mem_serve(1, 128'h5, 1, waited);

        // reset mid-SERVE_I
        drive(SRC_I, 1, 0, 16'h0777, '0);
        repeat (2) @(negedge clk);
        chk("mid_pread", p_if.read, 1);
        reset = 1'b1;
        drive(SRC_I, 0, 0, '0, '0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_pread0", p_if.read, 0);
        chk("mid_paddr0", p_if.address, 0);
        chk("mid_icnt0", i_cnt, 0);
        chk("mid_dcnt0", d_cnt, 0);
        p_if.resp = 1'b1;
        #1;
        chk("mid_idle_iresp", i_if.resp, 0);
        @(negedge clk);
        p_if.resp = 1'b0;

        // saturation: 2^CW + 3 I grants
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            drive(SRC_I, 1, 0, 16'(k), '0);
            sb.push_back('{1'b0, 16'(k), '0, SRC_I});
            @(negedge clk);
            mem_serve(0, 128'(k), 1, waited);
            if (k == 14) chk("sat_pre", i_cnt, 15);
        end
        chk("sat_icnt", i_cnt, 4'hF);
        chk("sat_dcnt", d_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
